// File: rtl/spi_cmd_master.sv
// spi_cmd_master: host-side SPI command master.
// Serialises one {cmd_type, cmd_data} command per frame (MSB first) and, for
// read-data commands, captures an 8-bit reply from MISO after RD_LAT idle cycles.
// All outputs come straight from flops; next values are derived from the
// next state so each output lines up with the state it belongs to.
// Optional build macro SPI_MASTER_CMD_FIFO_EN places a FIFO_DEPTH-entry command
// FIFO in front of the FSM (default build: commands accepted directly in IDLE).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ss_n high, waiting for a command
// START   | ss_n low, read/write select bit (cmd_type[1]) on MOSI
// SHIFT   | 10 frame bits on MOSI, bit 9 down to 0
// WAIT    | RD_LAT turnaround cycles before the reply (read-data only)
// CAPTURE | 8 MISO samples shifted in MSB first (read-data only)
// STOP    | ss_n high for one cycle, read reply published
module spi_cmd_master #(
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       MOSI,
  output logic       ss_n,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SHIFT,
    S_WAIT,
    S_CAPTURE,
    S_STOP
  } state_t;

  // Counter reload for WAIT; unused when RD_LAT is 0 (WAIT is skipped).
  localparam logic [3:0] WAIT_LOAD = (RD_LAT == 0) ? 4'd0 : 4'(RD_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [9:0] frame_q, frame_d;
  logic [7:0] cap_q, cap_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       ss_n_q, ss_n_d;
  logic       mosi_q, mosi_d;
  logic       busy_q, busy_d;
  logic       ready_q, ready_d;

  // Command source seen by the FSM in IDLE.
  logic       take;
  logic [9:0] take_frame;

`ifdef SPI_MASTER_CMD_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  logic [9:0]    fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   fcnt_q, fcnt_d;
  logic          push, pop;

  // A push is refused whenever the registered ready is low, including a
  // simultaneous pop on a full FIFO. Pops only see entries already stored.
  assign push       = cmd_valid && ready_q;
  assign pop        = (state_q == S_IDLE) && (fcnt_q != '0);
  assign take       = pop;
  assign take_frame = fifo_mem_q[rd_ptr_q];

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    fcnt_d = fcnt_q;
    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {cmd_type, cmd_data};
  end

  // FIFO pointers and count, flushed by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      fcnt_q <= fcnt_d;
    end
  end

  assign ready_d = (fcnt_d != FIFO_FULL);
  assign busy_d  = (state_d != S_IDLE) || (fcnt_d != '0);
`else
  assign take       = cmd_valid && ready_q;
  assign take_frame = {cmd_type, cmd_data};
  assign ready_d    = (state_d == S_IDLE);
  assign busy_d     = (state_d != S_IDLE);
`endif

  // Next-state, counter, capture and registered-output values.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    frame_d     = frame_q;
    cap_d       = cap_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (take) begin
          frame_d = take_frame;
          state_d = S_START;
        end
      end
      S_START: begin
        state_d   = S_SHIFT;
        bit_cnt_d = 4'd9;
      end
      S_SHIFT: begin
        if (bit_cnt_q == 4'd0) begin
          if (frame_q[9:8] == 2'b11) begin
            if (RD_LAT == 0) begin
              state_d   = S_CAPTURE;
              bit_cnt_d = 4'd7;
            end else begin
              state_d   = S_WAIT;
              bit_cnt_d = WAIT_LOAD;
            end
          end else begin
            state_d = S_STOP;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      S_WAIT: begin
        if (bit_cnt_q == 4'd0) begin
          state_d   = S_CAPTURE;
          bit_cnt_d = 4'd7;
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      S_CAPTURE: begin
        cap_d = {cap_q[6:0], MISO};
        if (bit_cnt_q == 4'd0) begin
          state_d     = S_STOP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = cap_d;
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      S_STOP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ss_n_d = (state_d == S_IDLE) || (state_d == S_STOP);
    mosi_d = 1'b0;
    if (state_d == S_START)      mosi_d = frame_d[9];
    else if (state_d == S_SHIFT) mosi_d = frame_d[bit_cnt_d];
  end

  // State and output registers; reset wins over a same-cycle accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 4'd0;
      frame_q     <= 10'd0;
      cap_q       <= 8'd0;
      rsp_data_q  <= 8'd0;
      rsp_valid_q <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_q     <= frame_d;
      cap_q       <= cap_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign MOSI      = mosi_q;
  assign ss_n      = ss_n_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Testbench for spi_cmd_master (default build, no command FIFO).
// Two instances run side by side: one with RD_LAT=2, one with RD_LAT=0.
// Expected waveforms are computed per cycle from the frame timing rules.
module tb_spi_cmd_master;

  localparam int LAT_A = 2;
  localparam int LAT_B = 0;

  logic       clk;
  logic       rst;
  logic       cv_a, cv_b;
  logic [1:0] cmd_type;
  logic [7:0] cmd_data;
  logic       miso;

  logic       rdy_a, rv_a, busy_a, mosi_a, ssn_a;
  logic [7:0] rd_a;
  logic       rdy_b, rv_b, busy_b, mosi_b, ssn_b;
  logic [7:0] rd_b;

  int checks;
  int errors;

  logic [7:0] exp_rsp_a;
  logic [7:0] exp_rsp_b;

  spi_cmd_master #(.RD_LAT(LAT_A), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .cmd_valid(cv_a), .cmd_ready(rdy_a),
    .cmd_type(cmd_type), .cmd_data(cmd_data), .rsp_valid(rv_a),
    .rsp_data(rd_a), .busy(busy_a), .MOSI(mosi_a), .ss_n(ssn_a), .MISO(miso)
  );

  spi_cmd_master #(.RD_LAT(LAT_B), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .cmd_valid(cv_b), .cmd_ready(rdy_b),
    .cmd_type(cmd_type), .cmd_data(cmd_data), .rsp_valid(rv_b),
    .rsp_data(rd_b), .busy(busy_b), .MOSI(mosi_b), .ss_n(ssn_b), .MISO(miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare one cycle of the selected instance; the other one must stay idle.
  task automatic check_cycle(input bit sel, input string tag, input logic e_ss,
                             input logic e_mosi, input logic e_rv,
                             input logic [7:0] e_rd, input logic e_busy,
                             input logic e_rdy);
    string p;
    p = sel ? {"B.", tag} : {"A.", tag};
    chk({p, ".ss_n"},      {7'd0, sel ? ssn_b  : ssn_a},  {7'd0, e_ss});
    chk({p, ".mosi"},      {7'd0, sel ? mosi_b : mosi_a}, {7'd0, e_mosi});
    chk({p, ".rsp_valid"}, {7'd0, sel ? rv_b   : rv_a},   {7'd0, e_rv});
    chk({p, ".rsp_data"},  sel ? rd_b : rd_a,             e_rd);
    chk({p, ".busy"},      {7'd0, sel ? busy_b : busy_a}, {7'd0, e_busy});
    chk({p, ".cmd_ready"}, {7'd0, sel ? rdy_b  : rdy_a},  {7'd0, e_rdy});
    chk({p, ".other_ss_n"}, {7'd0, sel ? ssn_a  : ssn_b},  8'd1);
    chk({p, ".other_busy"}, {7'd0, sel ? busy_a : busy_b}, 8'd0);
  endtask

  // Reference: MOSI in cycle k after the accepting edge.
  function automatic logic exp_mosi(input logic [9:0] fr, input int k);
    if (k == 1) return fr[9];
    if (k >= 2 && k <= 11) return fr[11 - k];
    return 1'b0;
  endfunction

  // Issue one command from an idle cycle and check every cycle of its frame.
  // hold keeps cmd_valid and the command stable through the frame.
  // abort_at>0 asserts reset during that cycle of the frame.
  task automatic run_cmd(input bit sel, input logic [1:0] t, input logic [7:0] d,
                         input logic [7:0] mb, input bit hold, input int abort_at);
    int         lat;
    int         stop;
    logic [9:0] fr;
    logic [7:0] er;
    bit         rd;
    lat  = sel ? LAT_B : LAT_A;
    rd   = (t == 2'b11);
    stop = rd ? 20 + lat : 12;
    fr   = {t, d};
    er   = sel ? exp_rsp_b : exp_rsp_a;

    check_cycle(sel, "idle", 1'b1, 1'b0, 1'b0, er, 1'b0, 1'b1);
    cmd_type = t;
    cmd_data = d;
    if (sel) cv_b = 1'b1; else cv_a = 1'b1;

    for (int k = 1; k <= stop; k++) begin
      @(negedge clk);
      if (!hold) begin
        cv_a     = 1'b0;
        cv_b     = 1'b0;
        cmd_type = 2'($urandom);
        cmd_data = 8'($urandom);
      end
      if (rd && k >= 12 + lat && k <= 19 + lat) miso = mb[19 + lat - k];
      else                                      miso = 1'($urandom_range(0, 1));
      if (rd && k == stop) er = mb;
      check_cycle(sel, $sformatf("k%0d", k), (k == stop), exp_mosi(fr, k),
                  (rd && k == stop), er, 1'b1, 1'b0);
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        cv_a      = 1'b0;
        cv_b      = 1'b0;
        exp_rsp_a = 8'h00;
        exp_rsp_b = 8'h00;
        check_cycle(sel, "post_rst", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        return;
      end
    end
    if (sel) exp_rsp_b = er; else exp_rsp_a = er;
    if (!hold) begin
      cv_a = 1'b0;
      cv_b = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    bit         sel;
    logic [1:0] t;
    logic [7:0] d;
    logic [7:0] mb;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    cv_a      = 1'b0;
    cv_b      = 1'b0;
    cmd_type  = 2'b00;
    cmd_data  = 8'h00;
    miso      = 1'b0;
    exp_rsp_a = 8'h00;
    exp_rsp_b = 8'h00;

    repeat (3) @(negedge clk);
    check_cycle(1'b0, "in_reset", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // Write address 0x3C
    run_cmd(1'b0, 2'b00, 8'h3C, 8'h00, 1'b0, 0);
    // Read data, RD_LAT=2, reply 0xA5
    run_cmd(1'b0, 2'b11, 8'h00, 8'hA5, 1'b0, 0);
    // Back-to-back with cmd_valid held: second accept lands at T+13
    run_cmd(1'b0, 2'b00, 8'h10, 8'h00, 1'b1, 0);
    run_cmd(1'b0, 2'b01, 8'h77, 8'h00, 1'b0, 0);
    // Reset in cycle T+6 of a write-data frame, then a clean read address
    run_cmd(1'b0, 2'b01, 8'hC3, 8'h00, 1'b0, 6);
    run_cmd(1'b0, 2'b10, 8'h05, 8'h00, 1'b0, 0);
    // Reset in the middle of a capture; the next read returns a fresh byte
    run_cmd(1'b0, 2'b11, 8'h00, 8'hFF, 1'b0, 17);
    run_cmd(1'b0, 2'b11, 8'h00, 8'h3C, 1'b0, 0);

    // Reset wins over a simultaneous accept
    cmd_type = 2'b01;
    cmd_data = 8'h5A;
    cv_a     = 1'b1;
    rst      = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    cv_a      = 1'b0;
    exp_rsp_a = 8'h00;
    exp_rsp_b = 8'h00;
    check_cycle(1'b0, "rst_vs_accept", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);

    // RD_LAT=0 read data
    run_cmd(1'b1, 2'b11, 8'h00, 8'h3E, 1'b0, 0);

    // Random command mix across both instances
    for (int i = 0; i < 24; i++) begin
      sel = 1'($urandom_range(0, 1));
      t   = 2'($urandom);
      d   = 8'($urandom);
      mb  = 8'($urandom);
      run_cmd(sel, t, d, mb, 1'b0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
